// File: rtl/csr_trap_ctrl_pkg.sv
// Shared CSR definitions: addresses, mstatus bit positions, trap FSM states.
package csr_define;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        S_IDLE           = 3'd0,
        S_SAVE_EPC       = 3'd1,
        S_SAVE_CAUSE     = 3'd2,
        S_SAVE_TVAL      = 3'd3,
        S_SAVE_STATUS    = 3'd4,
        S_RESTORE_STATUS = 3'd5,
        S_REDIRECT       = 3'd6
    } state_e;

endpackage

// File: rtl/csr_trap_ctrl_dff.sv
// Async-reset flop primitive, clears to zero.
module csr_dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= d;
    end

endmodule

// File: rtl/csr_trap_ctrl_trap_vec.sv
// Trap target PC from mtvec; VECTORED_MTVEC_EN enables vectored interrupts.
module trap_vec #(
    parameter int XLEN   = 64,
    parameter int IRQ_CW = 4
) (
    input  logic [XLEN-1:0]   mtvec,
    input  logic [IRQ_CW-1:0] irq_code,
    input  logic              is_irq,
    output logic [XLEN-1:0]   pc
);

    logic [XLEN-1:0] base;
    assign base = {mtvec[XLEN-1:2], 2'b00};

`ifdef VECTORED_MTVEC_EN
    logic vectored;
    assign vectored = is_irq && (mtvec[1:0] == 2'b01);
    assign pc = base + (vectored ? (XLEN'(irq_code) << 2) : '0);
`else
    logic unused_bits;
    assign unused_bits = ^{mtvec[1:0], irq_code, is_irq};
    assign pc = base;
`endif

endmodule

// File: rtl/csr_trap_ctrl.sv
// Trap/MRET sequencer: serialises mepc/mcause/mtval/mstatus writes, then redirects.
module csr_trap_ctrl
    import csr_define::*;
#(
    parameter int XLEN   = 64,
    parameter int IRQ_CW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csr_req_vaild,
    input  logic [11:0]       csr_req_addr,
    input  logic [XLEN-1:0]   csr_req_data,
    output logic              csr_req_ready,
    input  logic              exc_vaild,
    input  logic [XLEN-1:0]   exc_pc,
    input  logic [XLEN-1:0]   exc_cause,
    input  logic [XLEN-1:0]   exc_tval,
    input  logic              irq_pending,
    input  logic [IRQ_CW-1:0] irq_cause,
    input  logic              mret_vaild,
    input  logic [XLEN-1:0]   mstatus_qout,
    input  logic [XLEN-1:0]   mtvec_qout,
    input  logic [XLEN-1:0]   mepc_qout,
    output logic              csr_we,
    output logic [11:0]       csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              redirect_vaild,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush,
    output logic              busy
);

    state_e          state_q, state_d;
    logic [2:0]      state_raw;
    logic [XLEN-1:0] pc_q, pc_d, cause_q, cause_d, tval_q, tval_d;
    logic            mret_q, mret_d;
    logic            idle, take_trap, take_mret;
    logic [XLEN-1:0] trap_pc, st_save, st_restore;
    logic            unused_bits;

    csr_dff #(.W(3))    u_state (.clk(clk), .rst(rst), .d(state_d), .q(state_raw));
    csr_dff #(.W(XLEN)) u_pc    (.clk(clk), .rst(rst), .d(pc_d),    .q(pc_q));
    csr_dff #(.W(XLEN)) u_cause (.clk(clk), .rst(rst), .d(cause_d), .q(cause_q));
    csr_dff #(.W(XLEN)) u_tval  (.clk(clk), .rst(rst), .d(tval_d),  .q(tval_q));
    csr_dff #(.W(1))    u_mret  (.clk(clk), .rst(rst), .d(mret_d),  .q(mret_q));

    trap_vec #(.XLEN(XLEN), .IRQ_CW(IRQ_CW)) u_vec (
        .mtvec    (mtvec_qout),
        .irq_code (cause_q[IRQ_CW-1:0]),
        .is_irq   (cause_q[XLEN-1]),
        .pc       (trap_pc)
    );

    assign state_q   = state_e'(state_raw);
    assign idle      = (state_q == S_IDLE);
    assign take_trap = idle && (exc_vaild || (irq_pending && mstatus_qout[MSTATUS_MIE]));
    assign take_mret = idle && !take_trap && mret_vaild;
    // Reset holds state at IDLE, so ready needs its own gate.
    assign csr_req_ready = idle && !rst && !take_trap && !take_mret;
    assign busy          = !idle;
    assign redirect_vaild = (state_q == S_REDIRECT);
    assign flush          = redirect_vaild;
    assign unused_bits    = ^{mepc_qout[0], pc_q[0]};

    always_comb begin
        pc_d    = pc_q;
        cause_d = cause_q;
        tval_d  = tval_q;
        mret_d  = mret_q;
        if (take_trap) begin
            pc_d   = exc_pc;
            mret_d = 1'b0;
            if (exc_vaild) begin
                cause_d = exc_cause;
                tval_d  = exc_tval;
            end else begin
                cause_d = {1'b1, {(XLEN-1-IRQ_CW){1'b0}}, irq_cause};
                tval_d  = '0;
            end
        end else if (take_mret) begin
            mret_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (take_trap)      state_d = S_SAVE_EPC;
                else if (take_mret) state_d = S_RESTORE_STATUS;
            end
            S_SAVE_EPC:       state_d = S_SAVE_CAUSE;
            S_SAVE_CAUSE:     state_d = S_SAVE_TVAL;
            S_SAVE_TVAL:      state_d = S_SAVE_STATUS;
            S_SAVE_STATUS:    state_d = S_REDIRECT;
            S_RESTORE_STATUS: state_d = S_REDIRECT;
            default:          state_d = S_IDLE;
        endcase
    end

    always_comb begin
        st_save = mstatus_qout;
        st_save[MSTATUS_MPIE] = mstatus_qout[MSTATUS_MIE];
        st_save[MSTATUS_MIE]  = 1'b0;
        st_save[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        st_restore = mstatus_qout;
        st_restore[MSTATUS_MIE]  = mstatus_qout[MSTATUS_MPIE];
        st_restore[MSTATUS_MPIE] = 1'b1;
        st_restore[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_comb begin
        csr_we    = 1'b0;
        csr_waddr = '0;
        csr_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (csr_req_ready && csr_req_vaild) begin
                    csr_we    = 1'b1;
                    csr_waddr = csr_req_addr;
                    csr_wdata = csr_req_data;
                end
            end
            S_SAVE_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = {pc_q[XLEN-1:1], 1'b0};
            end
            S_SAVE_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MCAUSE;
                csr_wdata = cause_q;
            end
            S_SAVE_TVAL: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MTVAL;
                csr_wdata = tval_q;
            end
            S_SAVE_STATUS: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = st_save;
            end
            S_RESTORE_STATUS: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = st_restore;
            end
            default: ;
        endcase
    end

    always_comb begin
        redirect_pc = '0;
        if (redirect_vaild)
            redirect_pc = mret_q ? {mepc_qout[XLEN-1:1], 1'b0} : trap_pc;
    end

endmodule

// File: doc/csr_trap_ctrl.md
CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/PC width.
REQ-002 SHALL have parameter IRQ_CW, default 4, interrupt cause code width.
REQ-003 CLK  in  1  single clock, rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 csr_req_vaild  in  1  CSR-instruction write request.
REQ-006 csr_req_addr  in  12  target CSR address.
REQ-007 csr_req_data  in  XLEN  write data.
REQ-008 csr_req_ready  out  1  write request accepted this cycle.
REQ-009 exc_vaild, exc_pc, exc_cause, exc_tval  in  1/XLEN/XLEN/XLEN  committed exception.
REQ-010 irq_pending, irq_cause  in  1/IRQ_CW  enabled interrupt pending (mip&mie) and its code.
REQ-011 mret_vaild  in  1  committed MRET.
REQ-012 mstatus_qout, mtvec_qout, mepc_qout  in  XLEN each  current CSR values.
REQ-013 csr_we, csr_waddr, csr_wdata  out  1/12/XLEN  single CSR-file write port.
REQ-014 redirect_vaild, redirect_pc  out  1/XLEN  fetch redirect.
REQ-015 flush  out  1  pipeline flush pulse.
REQ-016 busy  out  1  high in every non-IDLE state.

Function
REQ-017 FSM states SHALL be IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, SAVE_STATUS, RESTORE_STATUS, REDIRECT.
REQ-018 In IDLE, priority SHALL be exc_vaild > (irq_pending & mstatus_qout[3]) > mret_vaild > csr_req_vaild.
REQ-019 Trap accept (cycle 0) SHALL capture pc, cause, tval into registers; interrupt uses pc=exc_pc, cause={1,zero-ext irq_cause}, tval=0.
REQ-020 Trap sequence SHALL be IDLE->SAVE_EPC->SAVE_CAUSE->SAVE_TVAL->SAVE_STATUS->REDIRECT->IDLE, one state per cycle.
REQ-021 SAVE_EPC/CAUSE/TVAL SHALL assert csr_we to 12'h341/12'h342/12'h343 with captured pc (bit0 cleared)/cause/tval.
REQ-022 SAVE_STATUS SHALL write 12'h300 with MPIE[7]<=MIE[3], MIE<=0, MPP[12:11]<=2'b11, other bits unchanged.
REQ-023 MRET sequence SHALL be IDLE->RESTORE_STATUS->REDIRECT->IDLE; RESTORE_STATUS writes MIE<=MPIE, MPIE<=1, MPP<=2'b11.
REQ-024 REDIRECT SHALL pulse redirect_vaild and flush for exactly one cycle; trap pc = {mtvec_qout[XLEN-1:2],2'b00}; MRET pc = mepc_qout with bit0 cleared.
REQ-025 csr_req_ready SHALL equal state==IDLE & no trap/MRET accepted that cycle; when ready&vaild, csr_we/waddr/wdata SHALL pass request through combinationally.
REQ-026 csr_we SHALL be 0 in REDIRECT and in IDLE without an accepted request.
REQ-027 exc_vaild, irq_pending, mret_vaild while busy SHALL be ignored (not queued); upstream holds commit while busy.
REQ-028 Latency: trap accept to redirect_vaild = 5 cycles; MRET = 2 cycles.
REQ-029 Simultaneous exc_vaild and mret_vaild SHALL take the exception; MRET is dropped.

Reset
REQ-030 RST SHALL force IDLE and all outputs to 0 (busy, csr_we, redirect_vaild, flush, csr_req_ready driven 0 while RST high), including mid-sequence, with no partial write after release.
REQ-031 Captured pc/cause/tval registers SHALL reset to 0.

Configuration
REQ-032 Macro VECTORED_MTVEC_EN: when defined and mtvec_qout[1:0]==2'b01 and trap is an interrupt, trap pc SHALL be base + 4*irq_cause; when undefined, direct mode always (mtvec[1:0] ignored).

Structure
REQ-033 CSR addresses, mstatus bit indices, FSM state encodings SHALL live in the shared csr_define package.
REQ-034 Trap-target computation SHALL be sub-module trap_vec (pure combinational: mtvec, cause, is_irq -> pc).
REQ-035 State and capture registers SHALL use the codebase async-reset flop primitive.

Verification
REQ-036 exc_vaild=1, exc_pc=0x8000_0010, cause=2, tval=0xDEAD, mtvec=0x8000_0100 -> writes 341=0x8000_0010, 342=2, 343=0xDEAD, 300 (MIE cleared), redirect 0x8000_0100 at cycle 5.
REQ-037 mstatus=0x8, irq_pending=1, irq_cause=11, mtvec=0x8000_0101, macro on -> mcause=0x8000_0000_0000_000B, redirect 0x8000_012C; macro off -> 0x8000_0100.
REQ-038 irq_pending=1 with mstatus[3]=0 and csr_req_vaild=1 -> no trap, csr_req_ready=1, request passes through.
REQ-039 mret_vaild=1, mstatus=0x80, mepc=0x8000_0201 -> write 300 with MIE=1,MPIE=1,MPP=3; redirect 0x8000_0200 after 2 cycles.
REQ-040 RST asserted in SAVE_CAUSE -> immediate IDLE, no further csr_we, no redirect; exc and mret same cycle -> exception sequence only.
